// File: rtl/csa_nibble_seq.sv
// csa_nibble_seq: multi-cycle W-bit adder that reuses one 4-bit carry-select slice, LSB nibble first.
// Latency: out_valid rises NIBBLES edges after the accept edge; the minimum issue interval is NIBBLES+2 cycles.
// Backpressure: in_ready is high only in IDLE; the result is held in DONE until out_ready is seen.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake for a, b, cin (and sub when CSA_SEQ_SUB_EN)
//   out_valid/out_ready result handshake for sum, cout
//   busy                high while a computation is in flight or a result is waiting
// Optional macro CSA_SEQ_SUB_EN adds input `sub` (1 = compute a - b, cout = no-borrow).

// 4-bit carry-select slice: two ripple sums (carry-in 0 and 1) selected by ci.
module csa (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] r0;
  logic [4:0] r1;

  assign r0 = {1'b0, a} + {1'b0, b};
  assign r1 = {1'b0, a} + {1'b0, b} + 5'd1;
  assign {co, s} = ci ? r1 : r0;
endmodule

module csa_nibble_seq #(
  parameter int NIBBLES = 4,
  parameter int W       = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
`ifdef CSA_SEQ_SUB_EN
  input  logic         sub,
`endif
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         busy
);
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic          carry;
  logic [CW-1:0] cnt;
  logic [3:0]    slice_s;
  logic          slice_co;
  logic          take_b_inv;

`ifdef CSA_SEQ_SUB_EN
  assign take_b_inv = sub;
`else
  assign take_b_inv = 1'b0;
`endif

  csa u_csa (
    .a  (a_sh[3:0]),
    .b  (b_sh[3:0]),
    .ci (carry),
    .s  (slice_s),
    .co (slice_co)
  );

  // Decoded from state only so the producer never sees a combinational path from in_valid.
  assign in_ready = (state == IDLE) && !rst;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            // Subtraction is a + ~b + 1: invert B and force the initial carry.
            b_sh  <= take_b_inv ? ~b : b;
            carry <= take_b_inv ? 1'b1 : cin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum[{cnt, 2'b00} +: 4] <= slice_s;
          carry <= slice_co;
          a_sh  <= a_sh >> 4;
          b_sh  <= b_sh >> 4;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            cout      <= slice_co;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
